// File: rtl/div_sequencer_pkg.sv
// rtl/div_sequencer_pkg.sv - shared state encodings and sizing helpers for the divide unit
package div_sequencer_pkg;

  localparam int DIV_STATE_BITS = 2;
  localparam logic [DIV_STATE_BITS-1:0] DIV_STATE_IDLE = 2'd0;
  localparam logic [DIV_STATE_BITS-1:0] DIV_STATE_RUN  = 2'd1;
  localparam logic [DIV_STATE_BITS-1:0] DIV_STATE_DONE = 2'd2;

  typedef enum logic [DIV_STATE_BITS-1:0] {
    S_IDLE = DIV_STATE_IDLE,
    S_RUN  = DIV_STATE_RUN,
    S_DONE = DIV_STATE_DONE
  } div_state_t;

  // One extra bit so the step counter can reach WIDTH without wrapping.
  function automatic int div_cnt_bits(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division step
module div_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH:0]   i_p,
  input  logic [WIDTH-1:0] i_q,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH:0]   o_p,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH+1:0] w_t;
  logic             w_ge;

  // P[WIDTH] is always 0 between steps, so carrying it in w_t leaves the compare unchanged.
  assign w_t  = {i_p, i_q[WIDTH-1]};
  assign w_ge = (w_t >= {2'b00, i_d});
  assign o_p  = w_ge ? (w_t[WIDTH:0] - {1'b0, i_d}) : w_t[WIDTH:0];
  assign o_q  = {i_q[WIDTH-2:0], w_ge};

endmodule

// File: rtl/div_sequencer.sv
// rtl/div_sequencer.sv - multi-cycle unsigned restoring divider, one quotient bit per cycle
module div_sequencer
  import div_sequencer_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_div_by_zero
);

  localparam int CNT_W = div_cnt_bits(WIDTH);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  div_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH:0]   r_p;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_d;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_div_by_zero;

  logic [WIDTH:0]   w_p_next;
  logic [WIDTH-1:0] w_q_next;

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_p (r_p),
    .i_q (r_q),
    .i_d (r_d),
    .o_p (w_p_next),
    .o_q (w_q_next)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_p           <= '0;
      r_q           <= '0;
      r_d           <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_quotient    <= '0;
      r_remainder   <= '0;
      r_div_by_zero <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (i_start) begin
            r_q    <= i_dividend;
            r_d    <= i_divisor;
            r_p    <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b1;
            // A zero divisor skips the shift loop and publishes its result immediately.
            if (i_divisor == '0) begin
              r_state       <= S_DONE;
              r_done        <= 1'b1;
              r_quotient    <= '1;
              r_remainder   <= i_dividend;
              r_div_by_zero <= 1'b1;
            end else begin
              r_state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          r_p   <= w_p_next;
          r_q   <= w_q_next;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST_STEP) begin
            r_state       <= S_DONE;
            r_done        <= 1'b1;
            r_quotient    <= w_q_next;
            r_remainder   <= w_p_next[WIDTH-1:0];
            r_div_by_zero <= 1'b0;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_quotient    = r_quotient;
  assign o_remainder   = r_remainder;
  assign o_div_by_zero = r_div_by_zero;

endmodule

// File: tb/tb_div_sequencer.sv
// tb/tb_div_sequencer.sv - directed and random self-checking bench for div_sequencer
module tb_div_sequencer;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int n_checks = 0;
  int n_errors = 0;

  div_sequencer #(.WIDTH(W)) dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_start       (start),
    .i_dividend    (dividend),
    .i_divisor     (divisor),
    .o_busy        (busy),
    .o_done        (done),
    .o_quotient    (quotient),
    .o_remainder   (remainder),
    .o_div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called 1 time unit after an edge while the unit is idle; returns in the first idle cycle after DONE.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp_q, input logic [W-1:0] exp_r,
                        input logic exp_z, input int exp_lat, input bit inject);
    int lat;
    int busy_cycles;
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    tick();
    start    = 1'b0;
    dividend = W'($urandom);
    divisor  = W'($urandom);
    lat = 1;
    busy_cycles = 0;
    while (lat < 40) begin
      if (busy) busy_cycles++;
      if (inject && (lat == 3 || lat == 17)) begin
        start    = 1'b1;
        dividend = 16'd1;
        divisor  = 16'd1;
      end else begin
        start = 1'b0;
      end
      if (done) break;
      tick();
      lat++;
    end
    check("latency", lat, exp_lat);
    check("busy_cycles", busy_cycles, exp_lat);
    check("quotient", quotient, exp_q);
    check("remainder", remainder, exp_r);
    check("div_by_zero", div_by_zero, exp_z);
    tick();
    start = 1'b0;
    check("busy_after_done", busy, 1'b0);
    check("done_one_cycle", done, 1'b0);
  endtask

  initial begin
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           lat;
    reset    = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    tick();
    tick();
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_quotient", quotient, 16'd0);
    check("rst_remainder", remainder, 16'd0);
    check("rst_dbz", div_by_zero, 1'b0);
    reset = 1'b0;
    tick();

    run_op(16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 17, 1'b0);
    run_op(16'd3, 16'd5, 16'd0, 16'd3, 1'b0, 17, 1'b0);
    run_op(16'hFFFF, 16'd1, 16'hFFFF, 16'd0, 1'b0, 17, 1'b0);
    run_op(16'hFFFF, 16'hFFFF, 16'd1, 16'd0, 1'b0, 17, 1'b0);
    run_op(16'd42, 16'd0, 16'hFFFF, 16'd42, 1'b1, 1, 1'b0);
    run_op(16'd9, 16'd3, 16'd3, 16'd0, 1'b0, 17, 1'b0);
    run_op(16'd0, 16'd0, 16'hFFFF, 16'd0, 1'b1, 1, 1'b0);

    // Start pulses during RUN and DONE must be dropped.
    run_op(16'd50, 16'd5, 16'd10, 16'd0, 1'b0, 17, 1'b1);
    tick();
    check("no_queued_start", busy, 1'b0);

    // Reset in the middle of a divide.
    start    = 1'b1;
    dividend = 16'd1000;
    divisor  = 16'd3;
    tick();
    start = 1'b0;
    lat = 1;
    while (lat < 8) begin
      tick();
      lat++;
    end
    check("mid_busy_before_reset", busy, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_done", done, 1'b0);
    check("mid_rst_quotient", quotient, 16'd0);
    check("mid_rst_remainder", remainder, 16'd0);
    check("mid_rst_dbz", div_by_zero, 1'b0);
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done || busy) lat++;
    end
    check("no_done_after_reset", lat, 0);
    run_op(16'd1000, 16'd3, 16'd333, 16'd1, 1'b0, 17, 1'b0);

    // Random soak, each op issued in the first idle cycle after the previous one.
    for (int i = 0; i < 1000; i++) begin
      a = W'($urandom);
      case ($urandom_range(0, 3))
        0:       b = 16'd0;
        1:       b = W'($urandom_range(1, 15));
        2:       b = W'($urandom_range(1, 255));
        default: b = W'($urandom);
      endcase
      if (b == 16'd0)
        run_op(a, b, 16'hFFFF, a, 1'b1, 1, 1'b0);
      else
        run_op(a, b, a / b, a % b, 1'b0, 17, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/div_sequencer.md
# div_sequencer

Multi-cycle unsigned divide unit for the fauxCPU datapath, issued by the main control FSM when an instruction decodes to `OP_DIVIDE`. It latches two operands on a start pulse and runs restoring division one quotient bit per cycle. It reports busy while running, so the control FSM can hold in its execute state. It then presents quotient and remainder with a one-cycle done pulse for register write-back.

## Interface
- `WIDTH`, default 16: operand, quotient and remainder width. Legal range is 2 to 32.
- `clk` input 1: single clock. All state updates on the rising edge.
- `reset` input 1: synchronous, active-high. Sampled on the rising edge of `clk`.
- `start` input 1: request a divide. Sampled only in state IDLE.
- `dividend` input WIDTH: unsigned numerator. Sampled with `start`.
- `divisor` input WIDTH: unsigned denominator. Sampled with `start`.
- `busy` output 1: high in states RUN and DONE.
- `done` output 1: single-cycle pulse, high in state DONE only.
- `quotient` output WIDTH: result. Registered.
- `remainder` output WIDTH: result. Registered.
- `div_by_zero` output 1: high when the last accepted operation had `divisor` equal to 0. Registered.

## Operation
- States are IDLE, RUN and DONE.
- IDLE with `start`=1:
  - Latch the operands. Clear the partial remainder P (WIDTH+1 bits) and the bit counter.
  - If `divisor`=0, go to DONE. Otherwise go to RUN.
- IDLE with `start`=0: stay in IDLE.
- RUN, each cycle:
  - Form T = {P[WIDTH-1:0], Q[WIDTH-1]}. Shift Q left by one.
  - If T ≥ {1'b0, D}: set P = T − D and Q[0] = 1. Otherwise set P = T and Q[0] = 0.
  - Increment the counter.
  - After the WIDTH-th step, go to DONE.
- DONE:
  - Assert `done`. Go to IDLE unconditionally on the next edge.
- Result registers are written on the edge that enters DONE, and then hold until the next result is written:
  - Normal case: `quotient`=Q, `remainder`=P[WIDTH-1:0], `div_by_zero`=0.
  - Divide by zero: `quotient`=all ones, `remainder`=dividend, `div_by_zero`=1.
- `start` is ignored while in RUN or DONE. It is not queued.
- Arithmetic is unsigned only. The counter is $clog2(WIDTH)+1 bits wide and cannot wrap.
- Reset, including mid-operation:
  - State goes to IDLE. Counter, P and Q are cleared.
  - `busy`=0, `done`=0, `quotient`=0, `remainder`=0, `div_by_zero`=0.
  - Any in-flight operation is discarded.

## Timing
- Let `start` be accepted at edge E0.
- Normal divide:
  - `busy` rises after E0.
  - RUN occupies the cycles after edges E0 through E(WIDTH−1).
  - DONE is the cycle after edge E(WIDTH), so `done` is high in that cycle. The result is valid from that same cycle.
  - Latency from start to done is WIDTH+1 edges. For WIDTH=16 that is 17 edges.
- Divide by zero: `done` is high in the cycle after E0. Latency is 1 edge.
- `busy` falls on the edge leaving DONE. A new `start` can be accepted on the edge after that, which gives a back-to-back throughput of WIDTH+2 cycles.
- `reset` takes priority over `start` on the same edge.
- Operands may change freely after E0 without affecting the result.

## Structure
- Add to the shared `param.v`:
  - `DIV_STATE_BITS`, plus encodings `DIV_STATE_IDLE`=0, `DIV_STATE_RUN`=1, `DIV_STATE_DONE`=2.
  - The existing `OP_DIVIDE` stays the control-side selector.
- Sub-module `div_step`, purely combinational: inputs P, Q and D; outputs next P and next Q.
  - One instance.
  - Unit-testable on its own.
- The top level holds the FSM, counter, operand registers and result registers.
- Integration: the control FSM asserts `start` in its execute state for `OP_DIVIDE`. It stalls while `busy`=1 and enables the register write on `done`.

## Test plan
- Reset, then 100 / 7 with WIDTH=16 -> `done` exactly 17 edges after the start edge; `quotient`=14, `remainder`=2, `div_by_zero`=0; `busy` high for 17 cycles.
- 3 / 5 -> `quotient`=0, `remainder`=3. Also 0xFFFF / 1 -> `quotient`=0xFFFF, `remainder`=0. Also 0xFFFF / 0xFFFF -> 1, 0.
- 42 / 0 -> `done` 1 edge after start; `quotient`=0xFFFF, `remainder`=42, `div_by_zero`=1. A following 9 / 3 clears `div_by_zero` and yields 3, 0.
- Start 50 / 5, then pulse `start` with 1 / 1 at cycles 3 and 17 (RUN and DONE) -> second request ignored; result is 10, 0; `busy` low after DONE.
- Assert `reset` at cycle 8 of a 1000 / 3 divide -> next cycle all outputs 0 and state IDLE, with no `done` pulse. A fresh 1000 / 3 then gives 333, 1.
- Random 1000-operation soak against a reference model. Include back-to-back starts issued on the first cycle `busy`=0.
